// File: rtl/hub_req.sv
// hub_req: cog-side initiator for hub_mem.
// Issues one byte/word/long access per request.
module hub_req #(
  parameter bit ROM_WP = 1'b1
) (
  input  logic        clk_cog,
  input  logic        nres,
  input  logic        ena_bus,
  input  logic        bus_sel,
  input  logic        req,
  input  logic        req_w,
  input  logic [1:0]  req_size,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        mem_w,
  output logic [3:0]  mem_wb,
  output logic [13:0] mem_a,
  output logic [31:0] mem_d,
  input  logic [31:0] mem_q
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2
  } state_t;

  state_t      st;
  logic        r_w;
  logic [1:0]  r_size;
  logic [15:0] r_addr;
  logic [31:0] r_data;

  logic        is_byte;
  logic        is_word;
  logic        is_long;
  logic [3:0]  lanes;
  logic [31:0] wdat;
  logic [31:0] rext;
  logic        own;
  logic        wr_ok;

  assign is_byte = (r_size == 2'b00);
  assign is_word = (r_size == 2'b01);
  assign is_long = r_size[1];

  // Lane enables, replicated write data and read extraction
  always_comb begin
    lanes = 4'b0000;
    wdat  = 32'h0;
    rext  = 32'h0;
    unique case (1'b1)
      is_byte: begin
        lanes = 4'b0001 << r_addr[1:0];
        wdat  = {4{r_data[7:0]}};
        unique case (r_addr[1:0])
          2'd0:    rext = {24'h0, mem_q[7:0]};
          2'd1:    rext = {24'h0, mem_q[15:8]};
          2'd2:    rext = {24'h0, mem_q[23:16]};
          default: rext = {24'h0, mem_q[31:24]};
        endcase
      end
      is_word: begin
        lanes = r_addr[1] ? 4'b1100 : 4'b0011;
        wdat  = {2{r_data[15:0]}};
        rext  = r_addr[1] ? {16'h0, mem_q[31:16]}
                          : {16'h0, mem_q[15:0]};
      end
      is_long: begin
        lanes = 4'b1111;
        wdat  = r_data;
        rext  = mem_q;
      end
      default: begin
        lanes = 4'b0000;
        wdat  = 32'h0;
        rext  = 32'h0;
      end
    endcase
  end

  // Bus is driven only while waiting and owning the slot;
  // ROM-region writes go out with no lanes and no strobe
  assign own    = (st == S_WAIT) && bus_sel;
  assign wr_ok  = r_w && !(ROM_WP && r_addr[15]);
  assign mem_w  = own && wr_ok;
  assign mem_wb = (own && wr_ok) ? lanes : 4'b0000;
  assign mem_a  = own ? r_addr[15:2] : 14'h0;
  assign mem_d  = own ? wdat : 32'h0;

  assign busy = (st != S_IDLE);

  // Request FSM: accept, wait for slot, capture read data
  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      st      <= S_IDLE;
      r_w     <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 16'h0;
      r_data  <= 32'h0;
      done    <= 1'b0;
      rd_data <= 32'h0;
    end else begin
      done <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (req) begin
            r_w    <= req_w;
            r_size <= req_size;
            r_addr <= req_addr;
            r_data <= req_data;
            st     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ena_bus && bus_sel) begin
            if (r_w) begin
              st   <= S_IDLE;
              done <= 1'b1;
            end else begin
              st <= S_CAPT;
            end
          end
        end
        S_CAPT: begin
          rd_data <= rext;
          done    <= 1'b1;
          st      <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub_req.sv
// tb_hub_req: directed bench for hub_req with a
// transaction-level reference model checked every cycle.
module tb_hub_req;

  logic        clk = 1'b0;
  logic        nres;
  logic        ena_bus;
  logic        bus_sel;
  logic        req;
  logic        req_w;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [31:0] req_data;
  logic        busy;
  logic        done;
  logic [31:0] rd_data;
  logic        mem_w;
  logic [3:0]  mem_wb;
  logic [13:0] mem_a;
  logic [31:0] mem_d;
  logic [31:0] mem_q;

  int total = 0;
  int bad = 0;
  int n_done = 0;

  hub_req dut (
    .clk_cog  (clk),
    .nres     (nres),
    .ena_bus  (ena_bus),
    .bus_sel  (bus_sel),
    .req      (req),
    .req_w    (req_w),
    .req_size (req_size),
    .req_addr (req_addr),
    .req_data (req_data),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .mem_w    (mem_w),
    .mem_wb   (mem_wb),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_q    (mem_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction
  bit        m_pend = 0;
  bit        m_got  = 0;
  bit        m_w    = 0;
  int        m_nb   = 1;
  int        m_addr = 0;
  bit [31:0] m_data = 0;
  bit        m_done = 0;
  bit [31:0] m_rd   = 0;

  function automatic int first_lane(int a, int nb);
    return ((a % 4) / nb) * nb;
  endfunction

  always @(posedge clk or negedge nres) begin
    if (!nres) begin
      m_pend = 0;
      m_got  = 0;
      m_done = 0;
      m_rd   = 0;
    end else begin
      bit nd;
      nd = 0;
      if (!m_pend) begin
        if (req) begin
          m_pend = 1;
          m_got  = 0;
          m_w    = req_w;
          m_nb   = (req_size == 0) ? 1 : (req_size == 1) ? 2 : 4;
          m_addr = int'(req_addr);
          m_data = req_data;
        end
      end else if (m_got) begin
        int fl;
        bit [31:0] msk;
        fl   = first_lane(m_addr, m_nb);
        msk  = (m_nb == 4) ? 32'hFFFF_FFFF
                           : (32'h1 << (8 * m_nb)) - 1;
        m_rd = (mem_q >> (8 * fl)) & msk;
        m_pend = 0;
        nd = 1;
      end else if (ena_bus && bus_sel) begin
        if (m_w) begin
          m_pend = 0;
          nd = 1;
        end else begin
          m_got = 1;
        end
      end
      m_done = nd;
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    bit        e_w;
    bit [3:0]  e_wb;
    bit [13:0] e_a;
    bit [31:0] e_d;
    int        fl;
    e_w  = 0;
    e_wb = 0;
    e_a  = 0;
    e_d  = 0;
    if (m_pend && !m_got && bus_sel) begin
      e_a = 14'(m_addr / 4);
      fl  = first_lane(m_addr, m_nb);
      for (int i = 0; i < 4; i++)
        e_d[8*i +: 8] = m_data[8*(i % m_nb) +: 8];
      if (m_w && m_addr < 'h8000) begin
        e_w = 1;
        for (int i = 0; i < 4; i++)
          if (i >= fl && i < fl + m_nb) e_wb[i] = 1'b1;
      end
    end
    if (done === 1'b1) n_done++;
    chk("busy", 32'(busy), 32'(m_pend));
    chk("done", 32'(done), 32'(m_done));
    chk("rd_data", rd_data, m_rd);
    chk("mem_w", 32'(mem_w), 32'(e_w));
    chk("mem_wb", 32'(mem_wb), 32'(e_wb));
    chk("mem_a", 32'(mem_a), 32'(e_a));
    if (e_w) chk("mem_d", mem_d, e_d);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic e, input logic s);
    ena_bus = e;
    bus_sel = s;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz,
                        input logic [15:0] a,
                        input logic [31:0] d);
    req      = 1'b1;
    req_w    = w;
    req_size = sz;
    req_addr = a;
    req_data = d;
    cyc();
    req = 1'b0;
  endtask

  initial begin
    int n0;
    nres = 1'b0;
    ena_bus = 0; bus_sel = 0; req = 0; req_w = 0;
    req_size = 0; req_addr = 0; req_data = 0; mem_q = 0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    cyc();
    nres = 1'b1;
    cyc();

    // byte write, slot three cycles after accept
    do_req(1, 2'b00, 16'h0005, 32'h0000_00AB);
    cyc();
    cyc();
    bus(1, 1);
    @(negedge clk);
    chk("bw_a", 32'(mem_a), 32'h1);
    chk("bw_wb", 32'(mem_wb), 32'b0010);
    chk("bw_d", mem_d, 32'hABAB_ABAB);
    chk("bw_w", 32'(mem_w), 32'd1);
    cyc();
    bus(0, 0);
    @(negedge clk);
    chk("bw_done", 32'(done), 32'd1);
    cyc();

    // word reads, upper and lower halves
    for (int k = 0; k < 2; k++) begin
      do_req(0, 2'b01, (k == 0) ? 16'h0012 : 16'h0010, 32'h0);
      cyc();
      bus(1, 1);
      @(negedge clk);
      chk("wr_wb", 32'(mem_wb), 32'h0);
      chk("wr_a", 32'(mem_a), 32'h4);
      cyc();
      bus(0, 0);
      mem_q = 32'h1234_5678;
      @(negedge clk);
      chk("wr_wait", 32'(done), 32'd0);
      cyc();
      mem_q = 32'h0;
      @(negedge clk);
      chk("wr_done", 32'(done), 32'd1);
      chk("wr_rd", rd_data,
          (k == 0) ? 32'h0000_1234 : 32'h0000_5678);
      cyc();
    end

    // long write, misaligned, foreign slot first
    do_req(1, 2'b10, 16'h0107, 32'hDEAD_BEEF);
    bus(1, 0);
    @(negedge clk);
    chk("lw_gate_w", 32'(mem_w), 32'd0);
    chk("lw_gate_d", mem_d, 32'h0);
    cyc();
    bus(0, 0);
    @(negedge clk);
    chk("lw_busy", 32'(busy), 32'd1);
    cyc();
    bus(1, 1);
    @(negedge clk);
    chk("lw_a", 32'(mem_a), 32'h41);
    chk("lw_wb", 32'(mem_wb), 32'hF);
    chk("lw_d", mem_d, 32'hDEAD_BEEF);
    cyc();
    bus(0, 0);
    cyc();

    // ROM-protected write still completes
    do_req(1, 2'b10, 16'hC000, 32'h5555_5555);
    bus(1, 1);
    @(negedge clk);
    chk("rom_w", 32'(mem_w), 32'd0);
    chk("rom_wb", 32'(mem_wb), 32'd0);
    cyc();
    bus(0, 0);
    @(negedge clk);
    chk("rom_done", 32'(done), 32'd1);
    cyc();

    // long read from the ROM region
    do_req(0, 2'b10, 16'h8004, 32'h0);
    bus(1, 1);
    cyc();
    bus(0, 0);
    mem_q = 32'hCAFE_F00D;
    cyc();
    mem_q = 32'h0;
    @(negedge clk);
    chk("rom_rd", rd_data, 32'hCAFE_F00D);
    cyc();

    // req held high: second accept in the done cycle
    req = 1; req_w = 1; req_size = 2'b10;
    req_addr = 16'h0200; req_data = 32'h1111_1111;
    cyc();
    bus(1, 1);
    @(negedge clk);
    chk("bb1_d", mem_d, 32'h1111_1111);
    cyc();
    bus(0, 0);
    req_addr = 16'h0204; req_data = 32'h2222_2222;
    @(negedge clk);
    chk("bb1_done", 32'(done), 32'd1);
    cyc();
    @(negedge clk);
    chk("bb2_busy", 32'(busy), 32'd1);
    cyc();
    bus(1, 1);
    @(negedge clk);
    chk("bb2_a", 32'(mem_a), 32'h81);
    chk("bb2_d", mem_d, 32'h2222_2222);
    cyc();
    bus(0, 0);
    req = 0;
    @(negedge clk);
    chk("bb2_done", 32'(done), 32'd1);
    cyc();

    // read with req held through WAIT and CAPT
    n0 = n_done;
    req = 1; req_w = 0; req_size = 2'b10; req_addr = 16'h0300;
    cyc();
    cyc();
    bus(1, 1);
    cyc();
    bus(0, 0);
    mem_q = 32'h55AA_55AA;
    cyc();
    req = 0;
    mem_q = 32'h0;
    @(negedge clk);
    chk("hr_rd", rd_data, 32'h55AA_55AA);
    cyc();
    cyc();
    chk("hr_ndone", 32'(n_done - n0), 32'd1);

    // reset while waiting for the slot
    do_req(1, 2'b10, 16'h0010, 32'h1234_5678);
    bus(0, 1);
    @(negedge clk);
    chk("rw_pre_w", 32'(mem_w), 32'd1);
    cyc();
    nres = 0;
    #1;
    chk("rw_w", 32'(mem_w), 32'd0);
    chk("rw_a", 32'(mem_a), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    cyc();
    bus(0, 0);
    nres = 1;
    @(negedge clk);
    chk("rw_done", 32'(done), 32'd0);
    cyc();

    // reset during capture
    do_req(0, 2'b10, 16'h0020, 32'h0);
    bus(1, 1);
    cyc();
    bus(0, 0);
    mem_q = 32'h7777_7777;
    nres = 0;
    #1;
    chk("rc_rd", rd_data, 32'h0);
    chk("rc_busy", 32'(busy), 32'd0);
    cyc();
    nres = 1;
    mem_q = 32'h0;
    @(negedge clk);
    chk("rc_done", 32'(done), 32'd0);
    cyc();

    // normal byte read after reset
    do_req(0, 2'b00, 16'h0023, 32'h0);
    bus(1, 1);
    cyc();
    bus(0, 0);
    mem_q = 32'hA1B2_C3D4;
    cyc();
    mem_q = 32'h0;
    @(negedge clk);
    chk("br_done", 32'(done), 32'd1);
    chk("br_rd", rd_data, 32'h0000_00A1);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
